// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - configuration bus and video output bundle for vga_timing_gen
//
// Purpose: groups the shadow-register write port and the timing outputs.
// Signals:
//   cfg_we, cfg_addr[2:0], cfg_wdata[CW-1:0], cfg_commit : master -> timing generator
//   cfg_busy                                             : commit pending
//   hsync, vsync, de, line_start, frame_start            : sync / enable / strobes
//   x, y, h_count, v_count [CW+1:0]                      : coordinates and raw counters
interface vga_timing_gen_if #(
  parameter int CW = 12
);
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          cfg_commit;
  logic          cfg_busy;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW+1:0] x;
  logic [CW+1:0] y;
  logic [CW+1:0] h_count;
  logic [CW+1:0] v_count;
  logic          line_start;
  logic          frame_start;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    input  cfg_busy, hsync, vsync, de, x, y, h_count, v_count, line_start, frame_start
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    output cfg_busy, hsync, vsync, de, x, y, h_count, v_count, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - runtime-reconfigurable VGA timing generator
//
// Purpose: horizontal/vertical counters, sync, data enable, pixel coordinates
// and line/frame strobes, advanced by a pixel-clock enable. Timing fields live
// in a shadow set (written any cycle) and an active set (loaded at frame wrap
// after a commit).
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   pix_ce  : pixel enable, timing advances only when high
//   bus     : vga_timing_gen_if.slave (config write/commit, busy, video outputs)
module vga_timing_gen #(
  parameter int   CW        = 12,
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  input logic              pix_ce,
  vga_timing_gen_if.slave  bus
);
  localparam int NW = CW + 2;
  typedef logic [NW-1:0] cnt_t;
  typedef logic [CW-1:0] fld_t;

  // Field order matches cfg_addr: [0..3] horizontal, [4..7] vertical.
  localparam logic [7:0][CW-1:0] RST_SET = {
    fld_t'(V_BACK), fld_t'(V_SYNC), fld_t'(V_FRONT), fld_t'(V_VISIBLE),
    fld_t'(H_BACK), fld_t'(H_SYNC), fld_t'(H_FRONT), fld_t'(H_VISIBLE)
  };
  localparam cnt_t H_TOT_RST = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam cnt_t V_TOT_RST = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);

  logic [7:0][CW-1:0] act_q;
  logic [7:0][CW-1:0] shd_q;
  logic [7:0][CW-1:0] shd_next;
  logic               pend_q;
  cnt_t               h_q, v_q, x_q, y_q;
  logic               hsync_q, vsync_q, de_q, ls_q, fs_q;

  function automatic cnt_t wid(input fld_t f);
    return cnt_t'(f);
  endfunction

  cnt_t h_tot, v_tot, hs_beg, hs_end, vs_beg, vs_end, h_nxt, v_nxt;
  logic h_end, v_end, wrap, hs_on, vs_on, de_nxt;

  assign h_tot  = wid(act_q[0]) + wid(act_q[1]) + wid(act_q[2]) + wid(act_q[3]);
  assign v_tot  = wid(act_q[4]) + wid(act_q[5]) + wid(act_q[6]) + wid(act_q[7]);
  assign h_end  = (h_q == h_tot - cnt_t'(1));
  assign v_end  = (v_q == v_tot - cnt_t'(1));
  assign wrap   = pix_ce && h_end && v_end;
  assign h_nxt  = h_end ? '0 : h_q + cnt_t'(1);
  assign v_nxt  = h_end ? (v_end ? '0 : v_q + cnt_t'(1)) : v_q;

  // Decode uses the set in force before the edge. At a wrap the new position
  // is (0,0), where every field is >= its minimum and the result is the same
  // for any set, so the new frame is still decoded correctly.
  assign hs_beg = wid(act_q[0]) + wid(act_q[1]);
  assign hs_end = hs_beg + wid(act_q[2]);
  assign vs_beg = wid(act_q[4]) + wid(act_q[5]);
  assign vs_end = vs_beg + wid(act_q[6]);
  assign hs_on  = (h_nxt >= hs_beg) && (h_nxt < hs_end);
  assign vs_on  = (v_nxt >= vs_beg) && (v_nxt < vs_end);
  assign de_nxt = (h_nxt < wid(act_q[0])) && (v_nxt < wid(act_q[4]));

  // Shadow contents including a write in this cycle, so a write coincident
  // with the wrap is part of the copy. Visible and sync fields (even
  // addresses) never hold 0.
  always_comb begin
    shd_next = shd_q;
    if (bus.cfg_we) begin
      if (bus.cfg_wdata == '0 && !bus.cfg_addr[0]) begin
        shd_next[bus.cfg_addr] = fld_t'(1);
      end else begin
        shd_next[bus.cfg_addr] = bus.cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q   <= RST_SET;
      shd_q   <= RST_SET;
      pend_q  <= 1'b0;
      h_q     <= H_TOT_RST - cnt_t'(1);
      v_q     <= V_TOT_RST - cnt_t'(1);
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      shd_q <= shd_next;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      if (pix_ce) begin
        h_q     <= h_nxt;
        v_q     <= v_nxt;
        hsync_q <= hs_on ? HSYNC_POL : ~HSYNC_POL;
        vsync_q <= vs_on ? VSYNC_POL : ~VSYNC_POL;
        de_q    <= de_nxt;
        x_q     <= de_nxt ? h_nxt : '0;
        y_q     <= de_nxt ? v_nxt : '0;
        ls_q    <= h_end;
        fs_q    <= h_end && v_end;
      end
      // A commit arriving on the wrap cycle is applied immediately.
      if (wrap && (pend_q || bus.cfg_commit)) begin
        act_q  <= shd_next;
        pend_q <= 1'b0;
      end else if (bus.cfg_commit) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign bus.cfg_busy    = pend_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.de          = de_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.h_count     = h_q;
  assign bus.v_count     = v_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, rst_n_b, ce_a, ce_b;
  int   mode_a, mode_b;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  vga_timing_gen_if #(.CW(12)) ifa ();
  vga_timing_gen_if #(.CW(12)) ifb ();

  vga_timing_gen #(.CW(12)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .pix_ce(ce_a), .bus(ifa)
  );

  vga_timing_gen #(
    .CW(12),
    .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .pix_ce(ce_b), .bus(ifb)
  );

  // Reference model: a frame is a linear run of pixel slots; position is the
  // slot index split by the line length.
  int def_a [8] = '{640, 16, 96, 48, 480, 10, 2, 33};
  int def_b [8] = '{20, 3, 4, 5, 6, 2, 2, 2};
  int act [2][8];
  int sh  [2][8];
  bit pend [2];
  int idx  [2];
  bit fresh[2];
  bit e_ls [2];
  bit e_fs [2];
  string onames [10] = '{"h_count", "v_count", "hsync", "vsync", "de",
                         "x", "y", "line_start", "frame_start", "cfg_busy"};

  function automatic int ht(int d);
    return act[d][0] + act[d][1] + act[d][2] + act[d][3];
  endfunction

  function automatic int vt(int d);
    return act[d][4] + act[d][5] + act[d][6] + act[d][7];
  endfunction

  function automatic int pol(int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic string nm(int d);
    return (d == 0) ? "A" : "B";
  endfunction

  task automatic model_reset(int d);
    for (int k = 0; k < 8; k++) begin
      act[d][k] = (d == 0) ? def_a[k] : def_b[k];
      sh[d][k]  = act[d][k];
    end
    pend[d]  = 1'b0;
    fresh[d] = 1'b1;
    e_ls[d]  = 1'b0;
    e_fs[d]  = 1'b0;
    idx[d]   = ht(d) * vt(d) - 1;
  endtask

  task automatic model_step(int d, bit rstn, bit ce, bit we, int addr, int wdata, bit commit);
    int nsh [8];
    bit wrap;
    if (!rstn) begin
      model_reset(d);
      return;
    end
    for (int k = 0; k < 8; k++) nsh[k] = sh[d][k];
    if (we) nsh[addr] = (wdata == 0 && (addr % 2) == 0) ? 1 : wdata;
    wrap = ce && (idx[d] == ht(d) * vt(d) - 1);
    e_ls[d] = 1'b0;
    e_fs[d] = 1'b0;
    if (ce) begin
      fresh[d] = 1'b0;
      idx[d]   = wrap ? 0 : idx[d] + 1;
      e_fs[d]  = wrap;
    end
    if (wrap && (pend[d] || commit)) begin
      for (int k = 0; k < 8; k++) act[d][k] = nsh[k];
      pend[d] = 1'b0;
    end else if (commit) begin
      pend[d] = 1'b1;
    end
    if (ce) e_ls[d] = (idx[d] % ht(d)) == 0;
    for (int k = 0; k < 8; k++) sh[d][k] = nsh[k];
  endtask

  function automatic logic [31:0] exp_out(int d, int k);
    int h, v, t;
    bit hs_a, vs_a, de_e;
    t    = ht(d);
    h    = idx[d] % t;
    v    = idx[d] / t;
    hs_a = (h >= act[d][0] + act[d][1]) && (h < act[d][0] + act[d][1] + act[d][2]);
    vs_a = (v >= act[d][4] + act[d][5]) && (v < act[d][4] + act[d][5] + act[d][6]);
    de_e = (h < act[d][0]) && (v < act[d][4]);
    if (fresh[d]) begin
      hs_a = 1'b0;
      vs_a = 1'b0;
      de_e = 1'b0;
    end
    case (k)
      0: return 32'(h);
      1: return 32'(v);
      2: return hs_a ? 32'(pol(d)) : 32'(1 - pol(d));
      3: return vs_a ? 32'(pol(d)) : 32'(1 - pol(d));
      4: return 32'(de_e);
      5: return de_e ? 32'(h) : 32'd0;
      6: return de_e ? 32'(v) : 32'd0;
      7: return 32'(e_ls[d]);
      8: return 32'(e_fs[d]);
      default: return 32'(pend[d]);
    endcase
  endfunction

  function automatic logic [31:0] dut_out(int d, int k);
    logic [13:0] h, v, xx, yy;
    logic hs, vs, dd, ls, fs, bz;
    if (d == 0) begin
      h = ifa.h_count; v = ifa.v_count; xx = ifa.x; yy = ifa.y;
      hs = ifa.hsync; vs = ifa.vsync; dd = ifa.de;
      ls = ifa.line_start; fs = ifa.frame_start; bz = ifa.cfg_busy;
    end else begin
      h = ifb.h_count; v = ifb.v_count; xx = ifb.x; yy = ifb.y;
      hs = ifb.hsync; vs = ifb.vsync; dd = ifb.de;
      ls = ifb.line_start; fs = ifb.frame_start; bz = ifb.cfg_busy;
    end
    case (k)
      0: return 32'(h);
      1: return 32'(v);
      2: return 32'(hs);
      3: return 32'(vs);
      4: return 32'(dd);
      5: return 32'(xx);
      6: return 32'(yy);
      7: return 32'(ls);
      8: return 32'(fs);
      default: return 32'(bz);
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_dut(int d);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s %s", nm(d), onames[k]), dut_out(d, k), exp_out(d, k));
  endtask

  function automatic logic next_ce(int mode);
    case (mode)
      1: return 1'b1;
      2: return logic'($urandom_range(0, 1));
      4: return (cyc % 4) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Inputs change only right after a tick returns, so the values read here
  // are the ones the DUT sampled on the preceding rising edge.
  task automatic tick();
    @(negedge clk);
    model_step(0, rst_n_a, ce_a, ifa.cfg_we, int'(ifa.cfg_addr), int'(ifa.cfg_wdata), ifa.cfg_commit);
    model_step(1, rst_n_b, ce_b, ifb.cfg_we, int'(ifb.cfg_addr), int'(ifb.cfg_wdata), ifb.cfg_commit);
    check_dut(0);
    check_dut(1);
    cyc++;
    ce_a = next_ce(mode_a);
    ce_b = next_ce(mode_b);
  endtask

  task automatic clear_cfg();
    ifa.cfg_we = 1'b0; ifa.cfg_addr = '0; ifa.cfg_wdata = '0; ifa.cfg_commit = 1'b0;
    ifb.cfg_we = 1'b0; ifb.cfg_addr = '0; ifb.cfg_wdata = '0; ifb.cfg_commit = 1'b0;
  endtask

  task automatic cfg_write(int d, int addr, int data, bit commit);
    if (d == 0) begin
      ifa.cfg_we = 1'b1; ifa.cfg_addr = 3'(addr); ifa.cfg_wdata = 12'(data); ifa.cfg_commit = commit;
    end else begin
      ifb.cfg_we = 1'b1; ifb.cfg_addr = 3'(addr); ifb.cfg_wdata = 12'(data); ifb.cfg_commit = commit;
    end
    tick();
    clear_cfg();
  endtask

  // Sync to a line_start, then measure one line: period in clks, clks with
  // hsync active, and the h_count where hsync is first/last active.
  task automatic measure_line(int d, int budget, output int per, output int hs_n,
                              output int hs_f, output int hs_l);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (dut_out(d, 7) == 1) begin ok = 1'b1; break; end
    end
    check($sformatf("%s line sync", nm(d)), 32'(ok), 32'd1);
    per = 0; hs_n = 0; hs_f = -1; hs_l = -1; ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      per++;
      if (dut_out(d, 7) == 1) begin ok = 1'b1; break; end
      if (dut_out(d, 2) == 32'(pol(d))) begin
        hs_n++;
        if (hs_f < 0) hs_f = int'(dut_out(d, 0));
        hs_l = int'(dut_out(d, 0));
      end
    end
    check($sformatf("%s line end", nm(d)), 32'(ok), 32'd1);
  endtask

  task automatic measure_frame(int d, int budget, output int per, output int vs_n,
                               output int vs_f, output int vs_l);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (dut_out(d, 8) == 1) begin ok = 1'b1; break; end
    end
    check($sformatf("%s frame sync", nm(d)), 32'(ok), 32'd1);
    per = 0; vs_n = 0; vs_f = -1; vs_l = -1; ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      per++;
      if (dut_out(d, 8) == 1) begin ok = 1'b1; break; end
      if (dut_out(d, 3) == 32'(pol(d))) begin
        vs_n++;
        if (vs_f < 0) vs_f = int'(dut_out(d, 1));
        vs_l = int'(dut_out(d, 1));
      end
    end
    check($sformatf("%s frame end", nm(d)), 32'(ok), 32'd1);
  endtask

  initial begin
    int per, cnt, f, l;
    bit ok, busy_dropped;

    rst_n_a = 1'b0; rst_n_b = 1'b0;
    ce_a = 1'b0; ce_b = 1'b0;
    mode_a = 0; mode_b = 0;
    clear_cfg();
    model_reset(0);
    model_reset(1);
    repeat (3) tick();
    check("A reset hsync", 32'(ifa.hsync), 32'd0);
    check("B reset hsync", 32'(ifb.hsync), 32'd1);
    check("B reset vsync", 32'(ifb.vsync), 32'd1);
    check("A reset h_count", 32'(ifa.h_count), 32'd799);
    check("A reset v_count", 32'(ifa.v_count), 32'd524);

    // Defaults, pix_ce every cycle.
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    mode_a = 1; mode_b = 1; ce_a = 1'b1; ce_b = 1'b1;
    tick();
    check("A first h", 32'(ifa.h_count), 32'd0);
    check("A first v", 32'(ifa.v_count), 32'd0);
    check("A first frame_start", 32'(ifa.frame_start), 32'd1);
    check("A first line_start", 32'(ifa.line_start), 32'd1);
    check("A first de", 32'(ifa.de), 32'd1);
    measure_line(0, 2000, per, cnt, f, l);
    check("A line period", 32'(per), 32'd800);
    check("A hsync clks", 32'(cnt), 32'd96);
    check("A hsync first", 32'(f), 32'd656);
    check("A hsync last", 32'(l), 32'd751);
    measure_line(1, 200, per, cnt, f, l);
    check("B line period", 32'(per), 32'd32);
    check("B hsync clks", 32'(cnt), 32'd4);
    check("B hsync first", 32'(f), 32'd23);
    measure_frame(1, 1000, per, cnt, f, l);
    check("B frame period", 32'(per), 32'd384);
    check("B vsync clks", 32'(cnt), 32'd64);
    check("B vsync first", 32'(f), 32'd8);
    check("B vsync last", 32'(l), 32'd9);

    // pix_ce every 4th clk on A.
    mode_a = 4;
    measure_line(0, 8000, per, cnt, f, l);
    check("A ce4 line period", 32'(per), 32'd3200);
    check("A ce4 hsync clks", 32'(cnt), 32'd384);
    check("A ce4 hsync first", 32'(f), 32'd656);
    mode_a = 1;

    // Reconfigure B mid-frame; new horizontal timing takes effect at the wrap.
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (idx[1] / ht(1) == 3) begin ok = 1'b1; break; end
      tick();
    end
    check("B reach v3", 32'(ok), 32'd1);
    cfg_write(1, 0, 320, 1'b0);
    cfg_write(1, 1, 8, 1'b0);
    cfg_write(1, 2, 48, 1'b0);
    cfg_write(1, 3, 24, 1'b1);
    check("B busy after commit", 32'(ifb.cfg_busy), 32'd1);
    measure_line(1, 200, per, cnt, f, l);
    check("B old line period", 32'(per), 32'd32);
    ok = 1'b0; busy_dropped = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (ifb.frame_start) begin ok = 1'b1; break; end
      if (!ifb.cfg_busy) busy_dropped = 1'b1;
    end
    check("B wrap seen", 32'(ok), 32'd1);
    check("B busy held", 32'(busy_dropped), 32'd0);
    check("B busy after wrap", 32'(ifb.cfg_busy), 32'd0);
    measure_line(1, 1000, per, cnt, f, l);
    check("B new line period", 32'(per), 32'd400);
    check("B new hsync clks", 32'(cnt), 32'd48);
    check("B new hsync first", 32'(f), 32'd328);
    check("B new hsync last", 32'(l), 32'd375);

    // V_SYNC=0 with the commit landing on the wrap cycle.
    cfg_write(1, 6, 0, 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      if (idx[1] == ht(1) * vt(1) - 1) begin ok = 1'b1; break; end
      tick();
    end
    check("B reach wrap", 32'(ok), 32'd1);
    ifb.cfg_commit = 1'b1;
    tick();
    clear_cfg();
    check("B wrap commit frame_start", 32'(ifb.frame_start), 32'd1);
    check("B wrap commit busy", 32'(ifb.cfg_busy), 32'd0);
    measure_frame(1, 10000, per, cnt, f, l);
    check("B vs1 frame period", 32'(per), 32'd4400);
    check("B vs1 vsync clks", 32'(cnt), 32'd400);
    check("B vs1 vsync first", 32'(f), 32'd8);
    check("B vs1 vsync last", 32'(l), 32'd8);

    // Randomized pixel enables, shadow writes and commits.
    mode_a = 2; mode_b = 2;
    for (int n = 0; n < 20000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        ifb.cfg_we = 1'b1;
        ifb.cfg_addr = 3'($urandom_range(0, 7));
        ifb.cfg_wdata = 12'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 63) == 0) ifb.cfg_commit = 1'b1;
      if ($urandom_range(0, 255) == 0) begin
        ifa.cfg_we = 1'b1;
        ifa.cfg_addr = 3'($urandom_range(0, 7));
        ifa.cfg_wdata = 12'($urandom_range(0, 4095));
        ifa.cfg_commit = 1'($urandom_range(0, 1));
      end
      tick();
      clear_cfg();
    end

    // Reset mid-frame with commits pending.
    mode_a = 1; mode_b = 1;
    cfg_write(0, 0, 100, 1'b1);
    cfg_write(1, 4, 3, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (idx[0] % ht(0) == 300 && !fresh[0]) begin ok = 1'b1; break; end
      tick();
    end
    check("A reach h300", 32'(ok), 32'd1);
    check("A busy before reset", 32'(ifa.cfg_busy), 32'd1);
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_dut(0);
    check_dut(1);
    check("A busy in reset", 32'(ifa.cfg_busy), 32'd0);
    check("A h in reset", 32'(ifa.h_count), 32'd799);
    check("B hsync in reset", 32'(ifb.hsync), 32'd1);
    repeat (2) tick();
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    measure_line(0, 2000, per, cnt, f, l);
    check("A restart line period", 32'(per), 32'd800);
    check("A restart hsync first", 32'(f), 32'd656);
    measure_line(1, 200, per, cnt, f, l);
    check("B restart line period", 32'(per), 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Runtime-reconfigurable VGA/video timing generator and successor to the fixed-mode sync controller. It produces horizontal and vertical counters, sync, data-enable, pixel coordinates and line/frame strobes. Timing is gated by a pixel-clock enable, so the block runs from the system clock. Porch, sync and visible lengths are programmable through a shadow register set that takes effect only at a frame boundary. The block sits between the pixel-clock divider and the pixel/framebuffer pipeline.

## Interface
- CW, 12: width of each timing field; counters and coordinates are CW+2 bits.
- H_VISIBLE / H_FRONT / H_SYNC / H_BACK, 640 / 16 / 96 / 48: reset values of the horizontal fields.
- V_VISIBLE / V_FRONT / V_SYNC / V_BACK, 480 / 10 / 2 / 33: reset values of the vertical fields.
- HSYNC_POL, 1: active level of hsync.
- VSYNC_POL, 1: active level of vsync.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- pix_ce  in  1  pixel enable; timing advances only on clk edges where it is high.
- cfg_we  in  1  write strobe for a shadow timing field.
- cfg_addr  in  3  field select: 0 H_VISIBLE, 1 H_FRONT, 2 H_SYNC, 3 H_BACK, 4 V_VISIBLE, 5 V_FRONT, 6 V_SYNC, 7 V_BACK.
- cfg_wdata  in  CW  write data.
- cfg_commit  in  1  one-cycle request to apply the shadow set at the next frame wrap.
- cfg_busy  out  1  commit pending.
- hsync  out  1  registered horizontal sync, at HSYNC_POL while active.
- vsync  out  1  registered vertical sync, at VSYNC_POL while active.
- de  out  1  data enable: high while in the visible area.
- x  out  CW+2  pixel column; 0 when de is low.
- y  out  CW+2  pixel row; 0 when de is low.
- h_count  out  CW+2  horizontal counter.
- v_count  out  CW+2  vertical counter.
- line_start  out  1  one-clk pulse when h_count becomes 0.
- frame_start  out  1  one-clk pulse when h_count and v_count both become 0.

## Operation
- Two register sets: shadow (written by cfg_we) and active (drives timing). Both reset to the parameter values.
- Totals: H_TOT = sum of the four active H fields; V_TOT = sum of the four active V fields. Arithmetic is CW+2 bits wide, with no overflow for legal CW values.
- A write of 0 to a VISIBLE or SYNC field stores 1. Front and back porches may be 0.
- cfg_we writes the shadow set on any clk edge, independent of pix_ce.
- On a pix_ce edge, h_count increments. At H_TOT-1, h_count wraps to 0 and v_count increments. When v_count is also at V_TOT-1, v_count wraps to 0 (the frame wrap).
- The wrap decision uses the active set in force before the wrap.
- Commit handling:
  - cfg_commit sets pending (cfg_busy=1).
  - At the next frame wrap, active <= shadow and pending clears. The frame starting at (0,0) uses the new timing.
  - A commit in the same cycle as a wrap applies at that wrap; cfg_busy stays 0.
  - Shadow writes while pending are allowed; the shadow contents at the wrap edge are applied.
  - A cfg_we and a wrap in the same cycle: the write is included in the copy.
- Decode, all from the new counter values:
  - hsync active for HV+HF <= h < HV+HF+HS.
  - vsync active for VV+VF <= v < VV+VF+VS.
  - de = (h<HV)&&(v<VV).
  - x/y = h/v when de is high, else 0.

## Timing
- All outputs are registered and updated only on pix_ce edges, except that line_start and frame_start clear on the next clk edge and cfg_busy follows the commit logic on every clk edge.
- hsync, vsync, de, x, y and the strobes are coherent with h_count/v_count in the same cycle (zero relative latency).
- Reset values:
  - h_count = H_TOT-1, v_count = V_TOT-1 (parameter totals).
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - de=0, x=y=0, line_start=frame_start=0, cfg_busy=0.
- The first pix_ce after reset release produces (0,0) with both strobes high and de=1.
- Reset asserted mid-frame or with a commit pending: all outputs return to their reset values immediately, pending clears, and shadow and active return to the parameter values.
- Strobes are exactly one clk wide, even when pix_ce is held high continuously.

## Test plan
- Reset, then pix_ce=1 each cycle, defaults. Required: first edge gives h=0, v=0, frame_start=1, line_start=1, de=1. hsync is high for h 656..751 (96 clks). Line period 800; vsync high for v 490..491; frame period 420000 clks.
- pix_ce high every 4th clk. Required: outputs change only on ce edges, strobes last 1 clk, line period 3200 clks.
- HSYNC_POL=0, VSYNC_POL=0. Required: hsync low for 96 ce cycles per line, vsync low for 2 lines, both idle high from reset.
- At v=100, write H_VISIBLE=320, H_FRONT=8, H_SYNC=48, H_BACK=24, then commit. Required: cfg_busy=1 until the frame wrap and the remaining lines stay at 800. After the wrap: lines of 400, hsync at h 328..375, cfg_busy=0.
- Write V_SYNC=0 with commit asserted on the wrap cycle. Required: applied at that wrap, cfg_busy never high, vsync 1 line wide.
- Assert rst_n low at h=300, v=200 with a commit pending. Required: immediate reset values, cfg_busy=0, default timing on restart.
